// File: rtl/es_pkg.sv
// Shared constants and state encoding for the sampling path and the display logic.
package es_pkg;

  localparam int ADC_W        = 10;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_PRE_TRIG = 64;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE
  } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// Capture buffer: one write port, one registered read port, maps onto a block RAM.
module capture_ram
  import es_pkg::*;
#(
  parameter int DATA_W = ADC_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rdata <= '0;
    else       r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_capture.sv
// ADC conversion clock, level-crossing trigger and pre/post-trigger window capture.
// state     | meaning
// IDLE      | no capture since reset
// PRE       | filling the pre-trigger part of the window, crossings ignored
// WAIT_TRIG | circular writes until a crossing or a forced trigger
// POST      | filling the remainder of the window after the trigger sample
// DONE      | buffer frozen, readback valid
module adc_capture
  import es_pkg::*;
#(
  parameter int DATA_W   = ADC_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PRE_TRIG = DEF_PRE_TRIG,
  parameter int ADC_DIV  = 2
) (
  input  logic              clk_10m,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              clk_adc,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_pos
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam int                DIV_W     = $clog2(ADC_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(ADC_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(ADC_DIV / 2);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 2);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);

  logic [DIV_W-1:0]  r_div_cnt;
  logic [DIV_W-1:0]  w_div_nxt;
  logic              r_clk_adc;
  logic              w_smp_stb;

  logic [DATA_W-1:0] r_cur;
  logic              r_cur_vld;
  logic              w_rise;
  logic              w_fall;
  logic              w_trig;
  logic              w_force;
  logic              w_we;

  cap_state_t        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_trig_pos;
  logic              r_busy;
  logic              r_done;
  logic              r_force_pend;
  logic [ADDR_W-1:0] w_rd_phys;

  assign w_div_nxt = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
  assign w_smp_stb = (r_div_cnt == DIV_HALF);

  always_ff @(posedge clk_10m or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_clk_adc <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_clk_adc <= (w_div_nxt < DIV_HALF);
    end
  end

  // The incoming sample plays the role of "cur" and the last strobed one of "prev",
  // so the sample that completes a crossing is the one written as the trigger sample.
  always_ff @(posedge clk_10m or posedge rst) begin
    if (rst) begin
      r_cur     <= '0;
      r_cur_vld <= 1'b0;
    end else if (w_smp_stb) begin
      r_cur     <= adc_data;
      r_cur_vld <= 1'b1;
    end
  end

  assign w_rise  = (r_cur < trig_level) && (adc_data >= trig_level);
  assign w_fall  = (r_cur > trig_level) && (adc_data <= trig_level);
  assign w_trig  = w_smp_stb && r_cur_vld && (trig_edge ? w_fall : w_rise);
  assign w_force = force_trig || r_force_pend;
  assign w_we    = w_smp_stb &&
                   ((r_state == PRE) || (r_state == WAIT_TRIG) || (r_state == POST));

  always_ff @(posedge clk_10m or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_cnt        <= '0;
      r_trig_pos   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_force_pend <= 1'b0;
    end else begin
      if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
      case (r_state)
        IDLE, DONE: begin
          if (arm) begin
            r_state  <= PRE;
            r_wr_ptr <= '0;
            r_cnt    <= PRE_LAST;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end
        end
        PRE: begin
          if (w_smp_stb) begin
            if (r_cnt == '0) r_state <= WAIT_TRIG;
            else             r_cnt   <= r_cnt - 1'b1;
          end
        end
        WAIT_TRIG: begin
          if (w_smp_stb) begin
            r_force_pend <= 1'b0;
            if (w_trig || w_force) begin
              r_state    <= POST;
              r_trig_pos <= r_wr_ptr;
              r_cnt      <= POST_LAST;
            end
          end else if (force_trig) begin
            r_force_pend <= 1'b1;
          end
        end
        POST: begin
          if (w_smp_stb) begin
            if (r_cnt == '0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_rd_phys = r_trig_pos - PRE_OFS + rd_addr;

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (clk_10m),
    .i_rst   (rst),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (adc_data),
    .i_raddr (w_rd_phys),
    .o_rdata (rd_data)
  );

  assign clk_adc  = r_clk_adc;
  assign busy     = r_busy;
  assign done     = r_done;
  assign trig_pos = r_trig_pos;

endmodule
